// File: rtl/sel_sequencer.sv
// Sweeps the downstream mode bit and 4-bit select through binary and/or one-hot
// patterns, holding each value for PRESCALE cycles.
module sel_sequencer #(
  parameter int unsigned PRESCALE = 100,
  parameter int unsigned CNT_W    = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode_req,
  input  logic       hold,
  output logic       sw,
  output logic [3:0] sel,
  output logic       busy,
  output logic       step_stb,
  output logic       done,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BIN  = 2'd1,
    OH   = 2'd2
  } state_e;

  // Terminal count is PRESCALE-1, which fits in CNT_W bits even when PRESCALE == 2**CNT_W.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             chain_q, chain_d;
  logic             sw_q, sw_d;
  logic [3:0]       sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             stb_q, stb_d;
  logic             done_q, done_d;
  logic [1:0]       idx_nxt;

  assign idx_nxt = idx_q + 2'd1;

  // start is a level request, taken only in IDLE; mode_req is latched in that same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    chain_d = chain_q;
    sw_d    = sw_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    stb_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (mode_req != 2'b11)) begin
          state_d = (mode_req == 2'b01) ? OH : BIN;
          chain_d = (mode_req == 2'b10);
          cnt_d   = '0;
          idx_d   = 2'd0;
          busy_d  = 1'b1;
          stb_d   = 1'b1;
          sw_d    = (mode_req == 2'b01);
          sel_d   = (mode_req == 2'b01) ? 4'b0001 : 4'h0;
        end
      end
      BIN, OH: begin
        if (!hold) begin
          if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cnt_d = '0;
            if (idx_q != 2'd3) begin
              idx_d = idx_nxt;
              stb_d = 1'b1;
              sel_d = (state_q == OH) ? (4'b0001 << idx_nxt) : {2'b00, idx_nxt};
            end else if ((state_q == BIN) && chain_q) begin
              state_d = OH;
              idx_d   = 2'd0;
              stb_d   = 1'b1;
              sw_d    = 1'b1;
              sel_d   = 4'b0001;
            end else begin
              state_d = IDLE;
              idx_d   = 2'd0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              sw_d    = 1'b0;
              sel_d   = 4'h0;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = 2'd0;
        busy_d  = 1'b0;
        sw_d    = 1'b0;
        sel_d   = 4'h0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      chain_q <= 1'b0;
      sw_q    <= 1'b0;
      sel_q   <= 4'h0;
      busy_q  <= 1'b0;
      stb_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      chain_q <= chain_d;
      sw_q    <= sw_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      stb_q   <= stb_d;
      done_q  <= done_d;
    end
  end

  assign sw        = sw_q;
  assign sel       = sel_q;
  assign busy      = busy_q;
  assign step_stb  = stb_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sel_sequencer.sv
// Bench for sel_sequencer: three instances (PRESCALE 4, 1, 128) share stimulus and are
// compared every cycle with a step-list model, plus table-driven sweeps and corner sequences.
module tb_sel_sequencer;

  localparam int ND = 3;
  localparam int PS [ND] = '{4, 1, 128};

  typedef struct packed {
    logic [1:0]  mode;
    logic [3:0]  n;
    logic [39:0] seq;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, start, hold;
  logic [1:0] mode_req;

  logic       sw_o   [ND];
  logic [3:0] sel_o  [ND];
  logic       busy_o [ND];
  logic       stb_o  [ND];
  logic       done_o [ND];
  logic [1:0] st_o   [ND];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int busy_cnt [ND];
  int done_cnt [ND];
  int stb_cnt  [ND];
  logic [6:0] cap_q [$];

  logic [4:0] steps_m [ND][8];
  int  n_m     [ND];
  int  pos_m   [ND];
  int  dwell_m [ND];
  bit  stb_m   [ND];
  bit  done_m  [ND];

  vec_t tbl [4];

  always #5 clk = ~clk;

  sel_sequencer #(.PRESCALE(4), .CNT_W(7)) dut0 (
    .clk(clk), .rst(rst), .start(start), .mode_req(mode_req), .hold(hold),
    .sw(sw_o[0]), .sel(sel_o[0]), .busy(busy_o[0]), .step_stb(stb_o[0]),
    .done(done_o[0]), .dbg_state(st_o[0])
  );
  sel_sequencer #(.PRESCALE(1), .CNT_W(7)) dut1 (
    .clk(clk), .rst(rst), .start(start), .mode_req(mode_req), .hold(hold),
    .sw(sw_o[1]), .sel(sel_o[1]), .busy(busy_o[1]), .step_stb(stb_o[1]),
    .done(done_o[1]), .dbg_state(st_o[1])
  );
  sel_sequencer #(.PRESCALE(128), .CNT_W(7)) dut2 (
    .clk(clk), .rst(rst), .start(start), .mode_req(mode_req), .hold(hold),
    .sw(sw_o[2]), .sel(sel_o[2]), .busy(busy_o[2]), .step_stb(stb_o[2]),
    .done(done_o[2]), .dbg_state(st_o[2])
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // The model holds the whole list of {sw,sel} values a sweep will present and walks it.
  task automatic model_step(input int i);
    if (rst) begin
      n_m[i] = 0; pos_m[i] = 0; dwell_m[i] = 0; stb_m[i] = 0; done_m[i] = 0;
    end else if (pos_m[i] >= n_m[i]) begin
      stb_m[i] = 0; done_m[i] = 0;
      if (start && mode_req != 2'b11) begin
        n_m[i] = 0;
        if (mode_req != 2'b01)
          for (int k = 0; k < 4; k++) begin steps_m[i][n_m[i]] = {1'b0, 4'(k)}; n_m[i]++; end
        if (mode_req != 2'b00)
          for (int k = 0; k < 4; k++) begin steps_m[i][n_m[i]] = {1'b1, 4'(1 << k)}; n_m[i]++; end
        pos_m[i] = 0; dwell_m[i] = PS[i]; stb_m[i] = 1;
      end
    end else if (hold) begin
      stb_m[i] = 0; done_m[i] = 0;
    end else begin
      stb_m[i] = 0; done_m[i] = 0;
      dwell_m[i]--;
      if (dwell_m[i] == 0) begin
        pos_m[i]++;
        if (pos_m[i] == n_m[i]) done_m[i] = 1;
        else begin stb_m[i] = 1; dwell_m[i] = PS[i]; end
      end
    end
  endtask

  function automatic logic [8:0] exp_out(input int i);
    if (pos_m[i] < n_m[i]) return {steps_m[i][pos_m[i]], 1'b1, stb_m[i], done_m[i]};
    return {5'b0, 1'b0, 1'b0, done_m[i]};
  endfunction

  function automatic logic [8:0] got_out(input int i);
    return {sw_o[i], sel_o[i], busy_o[i], stb_o[i], done_o[i]};
  endfunction

  function automatic bit any_busy();
    return busy_o[0] | busy_o[1] | busy_o[2];
  endfunction

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < ND; i++) model_step(i);
    @(negedge clk);
    cyc++;
    for (int i = 0; i < ND; i++) begin
      check($sformatf("cycle_dut%0d {sw,sel,busy,stb,done}", i), got_out(i), exp_out(i));
      if (busy_o[i]) busy_cnt[i]++;
      if (done_o[i]) done_cnt[i]++;
      if (stb_o[i]) begin
        stb_cnt[i]++;
        cap_q.push_back({2'(i), sw_o[i], sel_o[i]});
      end
    end
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int t = 0; t < max_cyc && any_busy(); t++) tick();
    n_checks++;
    if (any_busy()) begin
      n_fail++;
      $display("FAIL wait_idle timeout got=busy exp=idle (cycle %0d)", cyc);
    end
  endtask

  task automatic run_row(input int r);
    int bb [ND];
    int db [ND];
    int base, k;
    wait_idle(1200);
    for (int i = 0; i < ND; i++) begin bb[i] = busy_cnt[i]; db[i] = done_cnt[i]; end
    base = cap_q.size();
    mode_req = tbl[r].mode;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(1200);
    tick();
    for (int i = 0; i < ND; i++) begin
      k = 0;
      for (int j = base; j < cap_q.size(); j++) begin
        if (cap_q[j][6:5] == 2'(i)) begin
          if (k < 8) check($sformatf("row%0d_dut%0d_step%0d", r, i, k), cap_q[j][4:0],
                           tbl[r].seq[k*5 +: 5]);
          k++;
        end
      end
      check($sformatf("row%0d_dut%0d_nsteps", r, i), k, tbl[r].n);
      check($sformatf("row%0d_dut%0d_len", r, i), busy_cnt[i] - bb[i], tbl[r].n * PS[i]);
      check($sformatf("row%0d_dut%0d_done", r, i), done_cnt[i] - db[i], (tbl[r].n != 0) ? 1 : 0);
    end
  endtask

  initial begin
    int b0, s0, d0, base, sw1;
    int bz [ND];
    int dz [ND];

    tbl[0] = '{mode: 2'b00, n: 4'd4, seq: {20'h0, 5'h03, 5'h02, 5'h01, 5'h00}};
    tbl[1] = '{mode: 2'b01, n: 4'd4, seq: {20'h0, 5'h18, 5'h14, 5'h12, 5'h11}};
    tbl[2] = '{mode: 2'b10, n: 4'd8,
               seq: {5'h18, 5'h14, 5'h12, 5'h11, 5'h03, 5'h02, 5'h01, 5'h00}};
    tbl[3] = '{mode: 2'b11, n: 4'd0, seq: 40'h0};

    for (int i = 0; i < ND; i++) begin
      busy_cnt[i] = 0; done_cnt[i] = 0; stb_cnt[i] = 0;
      n_m[i] = 0; pos_m[i] = 0; dwell_m[i] = 0; stb_m[i] = 0; done_m[i] = 0;
    end

    rst = 1'b1; start = 1'b0; hold = 1'b0; mode_req = 2'b00;
    tick();
    tick();
    for (int i = 0; i < ND; i++) check($sformatf("reset_dut%0d", i), got_out(i), 9'h000);
    rst = 1'b0;
    tick();

    for (int r = 0; r < 4; r++) run_row(r);

    // One-hot sweep with a 5-cycle hold from the 2nd cycle of sel=0010.
    wait_idle(1200);
    b0 = busy_cnt[0]; s0 = stb_cnt[0];
    mode_req = 2'b01; start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 20 && !(stb_o[0] && sel_o[0] == 4'b0010); t++) tick();
    check("hold_reach_0010", sel_o[0], 4'b0010);
    tick();
    hold = 1'b1;
    repeat (5) tick();
    hold = 1'b0;
    for (int t = 0; t < 40 && busy_o[0]; t++) tick();
    check("hold_sweep_len", busy_cnt[0] - b0, 21);
    check("hold_stb_count", stb_cnt[0] - s0, 4);

    // start while busy is ignored, mode 11 in IDLE does nothing.
    wait_idle(1200);
    b0 = busy_cnt[0]; s0 = stb_cnt[0]; base = cap_q.size();
    mode_req = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    mode_req = 2'b01; start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 40 && busy_o[0]; t++) tick();
    sw1 = 0;
    for (int j = base; j < cap_q.size(); j++)
      if (cap_q[j][6:5] == 2'd0 && cap_q[j][4]) sw1++;
    check("restart_len", busy_cnt[0] - b0, 16);
    check("restart_stb", stb_cnt[0] - s0, 4);
    check("restart_sw_ones", sw1, 0);
    wait_idle(1200);
    for (int i = 0; i < ND; i++) begin bz[i] = busy_cnt[i]; dz[i] = done_cnt[i]; end
    mode_req = 2'b11; start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < ND; i++) begin
      check($sformatf("mode11_busy_dut%0d", i), busy_cnt[i] - bz[i], 0);
      check($sformatf("mode11_done_dut%0d", i), done_cnt[i] - dz[i], 0);
    end

    // Asynchronous reset during the 3rd value of a mode-10 sweep.
    wait_idle(1200);
    d0 = done_cnt[0];
    mode_req = 2'b10; start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 20 && !(stb_o[0] && sel_o[0] == 4'h2 && !sw_o[0]); t++) tick();
    check("rst_reach_3rd", {sw_o[0], sel_o[0]}, 5'h02);
    tick();
    rst = 1'b1;
    #1;
    for (int i = 0; i < ND; i++) check($sformatf("rst_async_dut%0d", i), got_out(i), 9'h000);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_no_done", done_cnt[0] - d0, 0);
    run_row(0);

    // Random stimulus against the model.
    for (int t = 0; t < 3000; t++) begin
      start    = ($urandom_range(0, 7) == 0);
      mode_req = 2'($urandom_range(0, 3));
      hold     = ($urandom_range(0, 4) == 0);
      rst      = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; start = 1'b0; hold = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
